// File: rtl/ahb2apb_bridge_ns.sv
// AHB-Lite slave to APB master bridge, single clock with an APB clock enable.
// Each AHB transfer becomes one APB access; out-of-range slave indices give a two-cycle ERROR.
module ahb2apb_bridge_ns #(
   parameter int ADDRWIDTH = 16,
   parameter int DATAWIDTH = 32,
   parameter int NSLV      = 4,
   parameter int SLV_LSB   = 12
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      HSEL,
   input  logic                      HREADYIN,
   input  logic                      HWRITE,
   input  logic [ADDRWIDTH-1:0]      HADDR,
   input  logic [1:0]                HTRANS,
   input  logic [2:0]                HSIZE,
   input  logic [3:0]                HPROT,
   input  logic [DATAWIDTH-1:0]      HWDATA,
   output logic                      HREADYOUT,
   output logic [1:0]                HRESP,
   output logic [DATAWIDTH-1:0]      HRDATA,
   input  logic                      PCLKEN,
   input  logic [NSLV-1:0]           PREADY,
   input  logic [NSLV-1:0]           PSLVERR,
   input  logic [NSLV*DATAWIDTH-1:0] PRDATA,
   output logic [NSLV-1:0]           PSEL,
   output logic                      PENABLE,
   output logic                      PWRITE,
   output logic [ADDRWIDTH-1:0]      PADDR,
   output logic [DATAWIDTH-1:0]      PWDATA,
   output logic [2:0]                PPROT,
   output logic [DATAWIDTH/8-1:0]    PSTRB,
   output logic                      APBACTIVE
);

   localparam int NB   = DATAWIDTH / 8;
   localparam int OFFW = $clog2(NB);

   typedef enum logic [2:0] {
      S_IDLE, S_PEND, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
   } state_t;

   state_t                 state_q, state_d;
   logic [NSLV-1:0]        sel_oh_q, sel_oh_d;
   logic [ADDRWIDTH-1:0]   addr_q;
   logic                   write_q;
   logic [2:0]             prot_q;
   logic [NB-1:0]          strb_q;
   logic [DATAWIDTH-1:0]   pwdata_q, hrdata_q;
   logic [NSLV-1:0]        psel_q;
   logic                   penable_q, hready_q, active_q;
   logic [1:0]             hresp_q;

   logic [3:0]             idx;
   logic                   idx_ok, cap, cap_state;
   logic                   pready_s, pslverr_s;
   logic [DATAWIDTH-1:0]   prdata_s;

   // Byte lanes covered by a 2^sz byte write starting at lane off.
   function automatic logic [NB-1:0] strb_f(input logic wr, input logic [2:0] sz,
                                            input logic [OFFW-1:0] off);
      logic [2*NB-1:0] m;
      m = '0;
      if (wr) begin
         if (32'(sz) >= OFFW) begin
            m[NB-1:0] = '1;
         end else begin
            for (int b = 0; b < NB; b++)
               if (b < (1 << sz)) m[b] = 1'b1;
            m = m << off;
         end
      end
      return m[NB-1:0];
   endfunction

   assign idx       = HADDR[SLV_LSB+3:SLV_LSB];
   assign cap_state = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
   assign cap       = HSEL && HREADYIN && (HTRANS == 2'b10 || HTRANS == 2'b11) && cap_state;

   always_comb begin
      sel_oh_d = '0;
      for (int i = 0; i < NSLV; i++)
         sel_oh_d[i] = (idx == 4'(i));
      idx_ok = |sel_oh_d;
   end

   // Only the captured slave's handshake and data are looked at.
   always_comb begin
      prdata_s = '0;
      for (int i = 0; i < NSLV; i++)
         if (sel_oh_q[i]) prdata_s = prdata_s | PRDATA[i*DATAWIDTH +: DATAWIDTH];
      pready_s  = |(PREADY & sel_oh_q);
      pslverr_s = |(PSLVERR & sel_oh_q);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERR2: begin
            if (cap) state_d = idx_ok ? S_PEND : S_ERR1;
            else     state_d = S_IDLE;
         end
         S_PEND:   if (PCLKEN) state_d = S_SETUP;
         S_SETUP:  if (PCLKEN) state_d = S_ACCESS;
         S_ACCESS: if (PCLKEN && pready_s) state_d = pslverr_s ? S_ERR1 : S_DONE;
         S_ERR1:   state_d = S_ERR2;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they change cleanly with it.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= S_IDLE;
         sel_oh_q  <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         prot_q    <= '0;
         strb_q    <= '0;
         pwdata_q  <= '0;
         hrdata_q  <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         hready_q  <= 1'b1;
         hresp_q   <= 2'b00;
         active_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         psel_q    <= (state_d == S_SETUP || state_d == S_ACCESS) ? sel_oh_q : '0;
         penable_q <= (state_d == S_ACCESS);
         hready_q  <= (state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR2);
         hresp_q   <= (state_d == S_ERR1 || state_d == S_ERR2) ? 2'b01 : 2'b00;
         active_q  <= (state_d != S_IDLE);
         if (cap) begin
            sel_oh_q <= sel_oh_d;
            addr_q   <= HADDR;
            write_q  <= HWRITE;
            prot_q   <= {~HPROT[0], 1'b0, HPROT[1]};
            strb_q   <= strb_f(HWRITE, HSIZE, HADDR[OFFW-1:0]);
         end
         // Write data is valid from the AHB data phase, which PEND waits out.
         if (state_q == S_PEND && PCLKEN)
            pwdata_q <= HWDATA;
         if (state_q == S_ACCESS && state_d == S_DONE && !write_q)
            hrdata_q <= prdata_s;
      end
   end

   assign HREADYOUT = hready_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = hrdata_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = write_q;
   assign PADDR     = addr_q;
   assign PWDATA    = pwdata_q;
   assign PPROT     = prot_q;
   assign PSTRB     = strb_q;
   assign APBACTIVE = active_q;

endmodule

// File: tb/tb_ahb2apb_bridge_ns.sv
// Directed bench for ahb2apb_bridge_ns: NSLV=4 main instance plus an NSLV=2 instance for decode errors.
module tb_ahb2apb_bridge_ns;

   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   always #5 HCLK = ~HCLK;

   logic        HSEL, HSEL2, HREADYIN, HWRITE;
   logic [15:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA;
   logic        PCLKEN;
   logic [3:0]  PREADY, PSLVERR;
   logic [127:0] PRDATA;

   logic        HREADYOUT, PENABLE, PWRITE, APBACTIVE;
   logic [1:0]  HRESP;
   logic [31:0] HRDATA, PWDATA;
   logic [3:0]  PSEL, PSTRB;
   logic [15:0] PADDR;
   logic [2:0]  PPROT;

   logic        HREADYOUT2, PENABLE2, PWRITE2, APBACTIVE2;
   logic [1:0]  HRESP2, PSEL2;
   logic [31:0] HRDATA2, PWDATA2;
   logic [3:0]  PSTRB2;
   logic [15:0] PADDR2;
   logic [2:0]  PPROT2;

   ahb2apb_bridge_ns u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADYIN(HREADYIN), .HWRITE(HWRITE),
      .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PCLKEN(PCLKEN),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PPROT(PPROT), .PSTRB(PSTRB),
      .APBACTIVE(APBACTIVE)
   );

   ahb2apb_bridge_ns #(.NSLV(2)) u_dut2 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL2), .HREADYIN(HREADYIN), .HWRITE(HWRITE),
      .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT2), .HRESP(HRESP2), .HRDATA(HRDATA2), .PCLKEN(PCLKEN),
      .PREADY(2'b11), .PSLVERR(2'b00), .PRDATA(64'h0), .PSEL(PSEL2), .PENABLE(PENABLE2),
      .PWRITE(PWRITE2), .PADDR(PADDR2), .PWDATA(PWDATA2), .PPROT(PPROT2), .PSTRB(PSTRB2),
      .APBACTIVE(APBACTIVE2)
   );

   // View of whichever instance the current transfer targets.
   logic       use2 = 1'b0;
   logic       m_ready;
   logic [1:0] m_resp;
   logic [3:0] m_psel;
   assign m_ready = use2 ? HREADYOUT2 : HREADYOUT;
   assign m_resp  = use2 ? HRESP2 : HRESP;
   assign m_psel  = use2 ? {2'b00, PSEL2} : PSEL;

   // PCLKEN: always high, or high one cycle in three.
   logic div3 = 1'b0;
   int   pcnt = 0;
   always @(negedge HCLK) begin
      if (div3) begin
         pcnt   = (pcnt == 2) ? 0 : pcnt + 1;
         PCLKEN = (pcnt == 0);
      end else begin
         PCLKEN = 1'b1;
      end
   end

   // Every visible APB state advance must follow an edge where PCLKEN was high.
   logic mon_en = 1'b0;
   int   adv_cnt = 0, adv_bad = 0;
   logic m_pc, m_ps, m_pe;
   always @(posedge HCLK) begin
      m_pc = PCLKEN; m_ps = |PSEL; m_pe = PENABLE;
      #1;
      if (mon_en && ((!m_ps && |PSEL) || (!m_pe && PENABLE) || (m_pe && !PENABLE))) begin
         adv_cnt++;
         if (!m_pc) adv_bad++;
      end
   end

   int n_chk = 0, n_err = 0;
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   int         w_waits;
   logic [3:0] w_psel, w_pstrb;
   logic [1:0] w_resp_prev, w_resp_end;

   // One AHB transfer; counts HREADYOUT-low cycles after the address phase.
   task automatic xfer(input logic d2, input logic [15:0] addr, input logic wr,
                       input logic [2:0] sz, input logic [31:0] wd, input int hold,
                       input logic [3:0] rdy_base);
      int   acc;
      logic done;
      use2   = d2;
      PREADY = rdy_base;
      @(negedge HCLK);
      HSEL = !d2; HSEL2 = d2; HTRANS = 2'b10; HADDR = addr;
      HWRITE = wr; HSIZE = sz; HPROT = 4'b0011;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HSEL2 = 1'b0; HTRANS = 2'b00; HWDATA = wd;
      w_waits = 0; w_psel = '0; w_pstrb = '0; w_resp_prev = '0; w_resp_end = '0;
      acc = 0; done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         if (m_ready) begin
            done = 1'b1;
            w_resp_end = m_resp;
         end else begin
            w_waits++;
            w_resp_prev = m_resp;
            w_psel = w_psel | m_psel;
            if (m_psel != 0) w_pstrb = PSTRB;
            if (PENABLE && !d2) begin
               acc++;
               if (acc > hold) PREADY = '1;
            end
            @(posedge HCLK); #1;
         end
      end
      if (!done) chk("xfer_timeout", 1, 0);
      PREADY = '1;
      use2 = 1'b0;
   endtask

   initial begin
      int a0;
      HSEL = 0; HSEL2 = 0; HREADYIN = 1; HWRITE = 0; HADDR = '0; HTRANS = 2'b00;
      HSIZE = 3'd2; HPROT = 4'b0011; HWDATA = '0;
      PREADY = '1; PSLVERR = '0;
      PRDATA = {32'h0BAD0003, 32'hA5A50001, 32'h0BAD0001, 32'h0BAD0000};

      #12;
      chk("rst_hready", HREADYOUT, 1);
      chk("rst_hresp", HRESP, 0);
      chk("rst_active", APBACTIVE, 0);
      chk("rst_psel", PSEL, 0);
      chk("rst_hrdata", HRDATA, 0);
      @(negedge HCLK); HRESETn = 1'b1;
      repeat (2) @(negedge HCLK);

      // BUSY and unselected NONSEQ must not start anything
      HSEL = 1; HTRANS = 2'b01; HADDR = 16'h1004;
      @(posedge HCLK); #1;
      chk("busy_nostart", APBACTIVE, 0);
      HSEL = 0; HTRANS = 2'b10;
      @(posedge HCLK); #1;
      chk("hsel0_nostart", APBACTIVE, 0);
      HTRANS = 2'b00;

      // word write to slave 1; other slaves show not-ready/error, which must be ignored
      PSLVERR = 4'b1101;
      xfer(0, 16'h1004, 1, 3'd2, 32'h12345678, 0, 4'b0010);
      PSLVERR = '0;
      chk("wr_waits", w_waits, 3);
      chk("wr_psel", w_psel, 4'b0010);
      chk("wr_pstrb", w_pstrb, 4'b1111);
      chk("wr_hresp", w_resp_end, 0);
      chk("wr_pwdata", PWDATA, 32'h12345678);
      chk("wr_paddr", PADDR, 16'h1004);
      chk("wr_pwrite", PWRITE, 1);
      chk("wr_pprot", PPROT, 3'b001);

      // read slave 2 with two not-ready ACCESS cycles
      xfer(0, 16'h2008, 0, 3'd2, 32'h0, 2, 4'b1011);
      chk("rd_waits", w_waits, 5);
      chk("rd_psel", w_psel, 4'b0100);
      chk("rd_pstrb", w_pstrb, 4'b0000);
      chk("rd_hrdata", HRDATA, 32'hA5A50001);

      // halfword write at lane 2
      xfer(0, 16'h0002, 1, 3'd1, 32'hBEEF0000, 0, 4'b1111);
      chk("hw_pstrb", w_pstrb, 4'b1100);
      chk("hw_psel", w_psel, 4'b0001);

      // slave error
      PSLVERR = 4'b0010;
      xfer(0, 16'h1000, 1, 3'd2, 32'h55, 0, 4'b1111);
      PSLVERR = '0;
      chk("err_waits", w_waits, 4);
      chk("err_resp1", w_resp_prev, 2'b01);
      chk("err_resp2", w_resp_end, 2'b01);
      chk("err_hrdata_hold", HRDATA, 32'hA5A50001);

      // decode error on the two-slave instance
      xfer(1, 16'h3000, 1, 3'd2, 32'h66, 0, 4'b1111);
      chk("dec_waits", w_waits, 1);
      chk("dec_psel", w_psel, 0);
      chk("dec_resp1", w_resp_prev, 2'b01);
      chk("dec_resp2", w_resp_end, 2'b01);

      // byte write with PCLKEN every third cycle
      a0 = adv_cnt;
      div3 = 1'b1; mon_en = 1'b1;
      xfer(0, 16'h1002, 1, 3'd0, 32'h00AB0000, 0, 4'b1111);
      mon_en = 1'b0; div3 = 1'b0;
      chk("div3_pstrb", w_pstrb, 4'b0100);
      chk("div3_adv_cnt", adv_cnt - a0, 3);
      chk("div3_adv_bad", adv_bad, 0);
      chk("div3_waits_gt3", (w_waits > 3), 1);

      // reset in ACCESS, then a clean transfer
      PREADY = 4'b1101;
      @(negedge HCLK);
      HSEL = 1; HTRANS = 2'b10; HADDR = 16'h1008; HWRITE = 1; HSIZE = 3'd2;
      @(posedge HCLK); #1;
      HSEL = 0; HTRANS = 2'b00; HWDATA = 32'h77;
      for (int c = 0; c < 20 && !PENABLE; c++) begin
         @(posedge HCLK); #1;
      end
      chk("rst_reach_access", PENABLE, 1);
      HRESETn = 1'b0;
      #1;
      chk("mrst_hready", HREADYOUT, 1);
      chk("mrst_hresp", HRESP, 0);
      chk("mrst_psel", PSEL, 0);
      chk("mrst_penable", PENABLE, 0);
      chk("mrst_pwrite", PWRITE, 0);
      chk("mrst_active", APBACTIVE, 0);
      chk("mrst_paddr", PADDR, 0);
      chk("mrst_pwdata", PWDATA, 0);
      chk("mrst_pprot", PPROT, 0);
      chk("mrst_pstrb", PSTRB, 0);
      chk("mrst_hrdata", HRDATA, 0);
      @(negedge HCLK); HRESETn = 1'b1; PREADY = '1;
      xfer(0, 16'h1008, 1, 3'd2, 32'hCAFE0001, 0, 4'b1111);
      chk("post_waits", w_waits, 3);
      chk("post_pwdata", PWDATA, 32'hCAFE0001);
      chk("post_hresp", w_resp_end, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
